// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for a 5-stage pipeline with a multi-cycle EX FSM and watchdog.
// Optional perf counters are enabled with `define PIPE_CTRL_PERF_EN.
module pipeline_ctrl #(
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic hazard_stall_i,
  input  logic branch_taken_i,
  input  logic mc_start_i,
  input  logic mc_done_i,
  input  logic imem_ready_i,
  input  logic dmem_req_i,
  input  logic dmem_ready_i,
  output logic pc_en_o,
  output logic ifid_en_o,
  output logic ifid_flush_o,
  output logic idex_en_o,
  output logic idex_flush_o,
  output logic exmem_en_o,
  output logic exmem_flush_o,
  output logic memwb_flush_o,
  output logic mc_busy_o,
  output logic mc_timeout_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] flush_events_o
`endif
);
  typedef enum logic [1:0] {RUN = 2'd0, MC_WAIT = 2'd1} state_t;
  localparam int WD_W = $clog2(MC_TIMEOUT) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MC_TIMEOUT - 1);
  state_t          r_state;
  logic [WD_W-1:0] r_wd_cnt;
  logic w_dstall, w_in_mc, w_mc_stall, w_mc_abort, w_redirect, w_hazard, w_fmiss;
  assign w_dstall   = dmem_req_i & ~dmem_ready_i;
  assign w_in_mc    = r_state == MC_WAIT;
  assign w_mc_stall = ~w_dstall & ~mc_done_i & (w_in_mc ? (r_wd_cnt < WD_LAST) : mc_start_i);
  assign w_mc_abort = ~w_dstall & w_in_mc & ~mc_done_i & (r_wd_cnt >= WD_LAST);
  // The aborted op never resolves, so a branch flag seen during the abort is ignored.
  assign w_redirect = ~w_dstall & ~w_mc_stall & ~w_mc_abort & branch_taken_i;
  assign w_hazard   = ~w_dstall & ~w_mc_stall & ~w_redirect & hazard_stall_i;
  assign w_fmiss    = ~w_dstall & ~w_mc_stall & ~w_redirect & ~hazard_stall_i & ~imem_ready_i;
  assign pc_en_o       = ~(w_dstall | w_mc_stall | w_hazard | w_fmiss);
  assign ifid_en_o     = ~(w_dstall | w_mc_stall | w_hazard);
  assign ifid_flush_o  = w_redirect | w_fmiss;
  assign idex_en_o     = ~(w_dstall | w_mc_stall);
  assign idex_flush_o  = w_redirect | w_hazard;
  assign exmem_en_o    = ~w_dstall;
  assign exmem_flush_o = w_mc_stall | w_mc_abort;
  assign memwb_flush_o = w_dstall;
  assign mc_busy_o     = w_in_mc;
  assign mc_timeout_o  = w_mc_abort;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_state  <= RUN;
      r_wd_cnt <= '0;
    end else if (!w_dstall) begin
      r_state  <= w_mc_stall ? MC_WAIT : RUN;
      r_wd_cnt <= w_mc_stall ? (w_in_mc ? r_wd_cnt + WD_W'(1) : WD_W'(1)) : '0;
    end
`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_stall_cnt <= (~pc_en_o & ~&r_stall_cnt) ? r_stall_cnt + CNT_W'(1) : r_stall_cnt;
      r_flush_cnt <= ((idex_flush_o | exmem_flush_o) & ~&r_flush_cnt) ? r_flush_cnt + CNT_W'(1) : r_flush_cnt;
    end
  assign stall_cycles_o = r_stall_cnt;
  assign flush_events_o = r_flush_cnt;
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: table-driven and sequence checks of pipeline_ctrl with a scoreboard queue.
module tb_pipeline_ctrl;
  logic clk = 0, rst_ni = 0;
  logic haz, br, mcs, mcd, imr, dreq, drdy;
  logic pc_en, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, exmem_fl, memwb_fl, busy, tmo;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cyc, flush_ev;
`endif
  int total = 0, bad = 0;
  logic [9:0] sb[$];
  always #5 clk = ~clk;
  pipeline_ctrl #(.MC_TIMEOUT(8), .CNT_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .hazard_stall_i(haz), .branch_taken_i(br),
    .mc_start_i(mcs), .mc_done_i(mcd), .imem_ready_i(imr), .dmem_req_i(dreq), .dmem_ready_i(drdy),
    .pc_en_o(pc_en), .ifid_en_o(ifid_en), .ifid_flush_o(ifid_fl), .idex_en_o(idex_en),
    .idex_flush_o(idex_fl), .exmem_en_o(exmem_en), .exmem_flush_o(exmem_fl),
    .memwb_flush_o(memwb_fl), .mc_busy_o(busy), .mc_timeout_o(tmo)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cycles_o(stall_cyc), .flush_events_o(flush_ev)
`endif
  );
  wire [9:0] outs = {pc_en, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, exmem_fl, memwb_fl, busy, tmo};
  // outs order: pc_en ifid_en ifid_fl idex_en idex_fl exmem_en exmem_fl memwb_fl busy timeout
  localparam logic [9:0] NORM = 10'b1101010000, HAZ = 10'b0001110000, RED = 10'b1111110000,
    FMISS = 10'b0111010000, DST = 10'b0000000100, DST_MC = 10'b0000000110,
    MC_RUN = 10'b0000011000, MC_W = 10'b0000011010, MC_EXIT = 10'b1101010010,
    TMO = 10'b1101011011;
  // inputs order: haz br mc_start mc_done imem_ready dmem_req dmem_ready
  localparam logic [6:0] IDLE = 7'b0000100, I_HAZ = 7'b1000100, I_MC = 7'b0010100,
    I_MCD = 7'b0011100, I_DMC = 7'b0010110;
  typedef struct {logic [6:0] in; logic [9:0] exp; string nm;} vec_t;
  vec_t vecs[14];
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask
  task automatic step(input logic [6:0] in, input logic [9:0] exp, input string nm);
    logic [9:0] e;
    {haz, br, mcs, mcd, imr, dreq, drdy} = in;
    sb.push_back(exp);
    @(negedge clk);
    e = sb.pop_front();
    check(nm, 32'(outs), 32'(e));
    @(posedge clk);
    #1;
  endtask
  initial begin
    vecs[0]  = '{IDLE,        NORM,  "normal"};
    vecs[1]  = '{I_HAZ,       HAZ,   "hazard"};
    vecs[2]  = '{7'b0100100,  RED,   "redirect"};
    vecs[3]  = '{7'b1100100,  RED,   "redirect_over_hazard"};
    vecs[4]  = '{7'b0000000,  FMISS, "fetch_miss"};
    vecs[5]  = '{7'b1000000,  HAZ,   "hazard_over_fmiss"};
    vecs[6]  = '{7'b0100000,  RED,   "redirect_over_fmiss"};
    vecs[7]  = '{7'b0000111,  NORM,  "dmem_ready"};
    vecs[8]  = '{7'b0000110,  DST,   "dstall"};
    vecs[9]  = '{7'b0100110,  DST,   "dstall_over_branch"};
    vecs[10] = '{7'b1000010,  DST,   "dstall_over_hazard"};
    vecs[11] = '{I_MCD,       NORM,  "mc_single_cycle"};
    vecs[12] = '{7'b1011100,  HAZ,   "mc_single_hazard"};
    vecs[13] = '{I_DMC,       DST,   "dstall_over_mc_start"};
    {haz, br, mcs, mcd, imr, dreq, drdy} = IDLE;
    #12;
    check("reset_outs", 32'(outs), 32'(NORM));
    @(negedge clk);
    rst_ni = 1;
    @(posedge clk);
    #1;
    foreach (vecs[i]) step(vecs[i].in, vecs[i].exp, vecs[i].nm);
    step(I_HAZ, HAZ, "haz2_c1");
    step(I_HAZ, HAZ, "haz2_c2");
    step(IDLE, NORM, "haz2_after");
    step(I_MC, MC_RUN, "mc_c1");
    step(I_MC, MC_W, "mc_c2");
    step(I_MC, MC_W, "mc_c3");
    step(I_MCD, MC_EXIT, "mc_done");
    step(IDLE, NORM, "mc_after");
    step(I_MC, MC_RUN, "mcb_c1");
    step(7'b0110100, MC_W, "mc_stall_over_branch");
    step(7'b0111100, 10'b1111110010, "mc_exit_redirect");
    step(I_MC, MC_RUN, "to_c1");
    for (int k = 2; k <= 7; k++) step(I_MC, MC_W, $sformatf("to_c%0d", k));
    step(IDLE, TMO, "to_pulse");
    step(IDLE, NORM, "to_after");
    step(I_MC, MC_RUN, "wd_c1");
    step(I_MC, MC_W, "wd_c2");
    for (int k = 0; k < 3; k++) step(I_DMC, DST_MC, $sformatf("wd_dstall%0d", k));
    for (int k = 0; k < 5; k++) step(I_MC, MC_W, $sformatf("wd_hold%0d", k));
    step(I_MC, TMO, "wd_pulse");
    step(IDLE, NORM, "wd_after");
    step(I_MC, MC_RUN, "rst_c1");
    step(I_MC, MC_W, "rst_c2");
    {haz, br, mcs, mcd, imr, dreq, drdy} = IDLE;
    rst_ni = 0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_timeout", 32'(tmo), 32'd0);
    @(negedge clk);
    rst_ni = 1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) step(I_HAZ, HAZ, $sformatf("perf_haz%0d", k));
    step(IDLE, NORM, "perf_idle");
`ifdef PIPE_CTRL_PERF_EN
    check("stall_cycles", stall_cyc, 32'd5);
    check("flush_events", flush_ev, 32'd5);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
